// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: finds the shift that normalizes an operand (CLZ/CTZ/CLS),
// one bit per cycle with early termination and a start/busy/done handshake.
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] r,
  output logic [CNT_W-1:0] shamt,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_work,  w_work_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [1:0]         r_mode,  w_mode_nxt;
  logic [WIDTH-1:0]   r_res,   w_res_nxt;
  logic [CNT_W-1:0]   r_shamt, w_shamt_nxt;
  logic               r_zero,  w_zero_nxt;
  logic               r_done,  w_done_nxt;

  logic w_is_ctz, w_is_cls, w_term;

  // Reserved mode 11 falls through to CLZ behaviour.
  assign w_is_ctz = (r_mode == 2'b01);
  assign w_is_cls = (r_mode == 2'b10);

  always_comb begin
    w_term = 1'b0;
    if (w_is_cls)
      w_term = (r_work[WIDTH-1] ^ r_work[WIDTH-2]) || (r_cnt == 6'd31);
    else if (w_is_ctz)
      w_term = r_work[0] || (r_cnt == 6'd32);
    else
      w_term = r_work[WIDTH-1] || (r_cnt == 6'd32);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_res_nxt   = r_res;
    w_shamt_nxt = r_shamt;
    w_zero_nxt  = r_zero;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_work_nxt  = a;
          w_cnt_nxt   = '0;
          w_mode_nxt  = mode;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Flush wins over termination; result registers are left untouched.
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_term) begin
          w_res_nxt   = r_work;
          w_shamt_nxt = r_cnt;
          w_zero_nxt  = !w_is_cls && (r_cnt == 6'd32);
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_work_nxt = w_is_ctz ? (r_work >> 1) : (r_work << 1);
          w_cnt_nxt  = r_cnt + 6'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_res   <= '0;
      r_shamt <= '0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_res   <= w_res_nxt;
      r_shamt <= w_shamt_nxt;
      r_zero  <= w_zero_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign r     = r_res;
  assign shamt = r_shamt;
  assign zero  = r_zero;
  assign done  = r_done;
  assign busy  = (r_state == S_RUN);

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: hand-computed vectors, handshake,
// flush and asynchronous reset behaviour.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] r;
  logic [5:0]  shamt;
  logic        zero, busy, done;

  int checks = 0;
  int failures = 0;

  shift_normalizer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .mode(mode),
    .a(a), .r(r), .shamt(shamt), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an operation from the current sampling point (accepting edge is the
  // next posedge) and checks the result and edge count once done is seen.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] v,
                        input logic [5:0] exp_sh, input logic [31:0] exp_r,
                        input logic exp_z, input int exp_edges);
    int edges;
    logic busy_bad;
    start = 1'b1; mode = m; a = v;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; mode = 2'b01 ^ m;
    edges = 0;
    busy_bad = 1'b0;
    while (!done && edges < 40) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_busy_thru"}, busy_bad, 1'b0);
    chk({tag, "_edges"}, edges, exp_edges);
    chk({tag, "_shamt"}, shamt, exp_sh);
    chk({tag, "_r"}, r, exp_r);
    chk({tag, "_zero"}, zero, exp_z);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_r", r, 32'h0);
    chk("rst_shamt", shamt, 6'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op("clz_bit16", 2'b00, 32'h0001_0000, 6'd15, 32'h8000_0000, 1'b0, 16);
    run_op("ctz_a00",   2'b01, 32'h0000_0A00, 6'd9,  32'h0000_0005, 1'b0, 10);
    run_op("clz_msb",   2'b00, 32'h8000_0000, 6'd0,  32'h8000_0000, 1'b0, 1);
    run_op("cls_f800",  2'b10, 32'hFFFF_F800, 6'd20, 32'h8000_0000, 1'b0, 21);
    run_op("cls_ones",  2'b10, 32'hFFFF_FFFF, 6'd31, 32'h8000_0000, 1'b0, 32);
    run_op("cls_zero",  2'b10, 32'h0000_0000, 6'd31, 32'h0000_0000, 1'b0, 32);
    run_op("clz_zero",  2'b00, 32'h0000_0000, 6'd32, 32'h0000_0000, 1'b1, 33);
    run_op("ctz_zero",  2'b01, 32'h0000_0000, 6'd32, 32'h0000_0000, 1'b1, 33);
    chk("b2b_done_high", done, 1'b1);
    run_op("clz_one_b2b", 2'b00, 32'h0000_0001, 6'd31, 32'h8000_0000, 1'b0, 32);
    run_op("rsvd_clz",  2'b11, 32'h0040_0000, 6'd9,  32'h8000_0000, 1'b0, 10);

    // Results hold after the done pulse.
    @(posedge clk); #1;
    chk("hold_done_low", done, 1'b0);
    chk("hold_shamt", shamt, 6'd9);

    // Flush at the 5th RUN edge, with an ignored start while busy.
    start = 1'b1; mode = 2'b00; a = 32'h0000_00FF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 32'h0000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fl_busy_mid", busy, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy_drop", busy, 1'b0);
    chk("fl_no_done", done, 1'b0);
    chk("fl_r_kept", r, 32'h8000_0000);
    chk("fl_shamt_kept", shamt, 6'd9);
    chk("fl_zero_kept", zero, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("fl_still_idle", busy, 1'b0);
    chk("fl_still_no_done", done, 1'b0);

    // Flush in IDLE blocks acceptance.
    start = 1'b1; flush = 1'b1; a = 32'h0000_0010;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("fl_idle_block", busy, 1'b0);

    // Asynchronous reset mid-RUN.
    start = 1'b1; mode = 2'b00; a = 32'h0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_r", r, 32'h0);
    chk("arst_shamt", shamt, 6'd0);
    chk("arst_zero", zero, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_ctz", 2'b01, 32'h8000_0000, 6'd31, 32'h0000_0001, 1'b0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Multi-cycle normalizer for the execute stage; the inverse of the barrel shifter. The shifter takes a value and a shift amount and produces the shifted result; this block takes a value and finds the shift amount that normalizes it.
- Three modes: count-leading-zeros (CLZ), count-trailing-zeros (CTZ), count-leading-redundant-sign-bits (CLS). Each mode returns the count and the normalized value.
- Processes one bit per cycle with early termination. Start/busy/done handshake to the pipeline control, plus a flush input.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; CNT_W = 6.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  abort the current operation (pipeline flush)
- mode  input  2  00 CLZ, 01 CTZ, 10 CLS, 11 reserved (behaves as CLZ)
- a  input  32  operand; sampled on the accepting edge only
- r  output  32  normalized value
- shamt  output  6  computed count, 0..32
- zero  output  1  operand was all zeros (CLZ/CTZ only)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a result is valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; r=0, shamt=0, zero=0, busy=0, done=0; internal working register and counter cleared. Reset mid-RUN aborts with no done.
- States:
  - IDLE: on a clk edge with start=1 and flush=0, load work=a, cnt=0, latch mode, go to RUN. Otherwise stay. done returns to 0 one cycle after a pulse.
  - RUN (busy=1): each edge, evaluate the termination test on the current work/cnt.
    - Terminate: r<=work, shamt<=cnt, zero<=(CLZ/CTZ and cnt==32), done<=1, go to IDLE.
    - Otherwise: shift work one bit, cnt<=cnt+1.
- Termination tests:
  - CLZ: work[31]==1 or cnt==32. Shift: work<<1, zero fill.
  - CTZ: work[0]==1 or cnt==32. Shift: logical work>>1.
  - CLS: work[31]!=work[30] or cnt==31. Shift: work<<1. zero is always 0 in this mode.
- Latency: a count of n gives done high in the cycle after edge E0+n+1, where E0 is the accepting edge. Worst case is 33 edges (zero operand, CLZ/CTZ).
- Start while busy is ignored (no queuing).
- A start in the same cycle that done is high is accepted, since the state is already IDLE. Back-to-back throughput needs no idle gap.
- flush=1 in RUN: go to IDLE next edge, no done pulse, and r/shamt/zero keep their previous values. flush=1 in IDLE blocks acceptance of start. Flush has priority over termination on the same edge.
- r/shamt/zero are held stable from done until the next termination.
- Invariants for nonzero results:
  - CLZ: r>>shamt == a.
  - CTZ: r<<shamt == a.
  - CLS: $signed(r)>>>shamt == a.
- shamt is unsigned 6-bit. The counter never exceeds 32 (31 in CLS).

Test Plan:
- CLZ a=0x0001_0000 -> shamt=15, r=0x8000_0000, zero=0, done 16 edges after accept; busy high throughout.
- CTZ a=0x0000_0A00 -> shamt=9, r=0x0000_0005, zero=0; CLZ a=0x8000_0000 -> shamt=0, done after 1 edge.
- CLS a=0xFFFF_F800 -> shamt=20, r=0x8000_0000. CLS a=0xFFFF_FFFF -> shamt=31, r=0x8000_0000. CLS a=0 -> shamt=31, r=0, zero=0.
- CLZ a=0 and CTZ a=0 -> shamt=32, r=0, zero=1, done after 33 edges. Immediately restart in the done cycle with CLZ a=1 -> shamt=31.
- Start CLZ a=0x0000_00FF, pulse start with a=0x1 while busy (ignored), assert flush at the 5th RUN edge -> no done, outputs keep prior values, busy drops next edge.
- Drive rst_n low asynchronously mid-RUN (between edges) -> busy, done, r, shamt drop to 0 immediately. A new start after release operates normally.
